// File: rtl/zr_uart_pkg.sv
// Shared definitions for the zr_uart transmitter: FSM states and frame-format limits.
package zr_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    localparam int unsigned BITS_MIN  = 5;
    localparam int unsigned BITS_MAX  = 8;
    localparam int unsigned STOPS_MIN = 1;
    localparam int unsigned STOPS_MAX = 2;

    // Index of the last data bit for a requested width, clamped to the legal range.
    function automatic logic [2:0] clamp_bits_m1(input logic [3:0] bits);
        if (bits < 4'(BITS_MIN))
            return 3'(BITS_MIN - 1);
        else if (bits > 4'(BITS_MAX))
            return 3'(BITS_MAX - 1);
        else
            return 3'(bits - 4'd1);
    endfunction

    // Index of the last stop bit (0 for one stop bit, 1 for two).
    function automatic logic clamp_stops_m1(input logic [1:0] stops);
        if (stops >= 2'(STOPS_MAX))
            return 1'b1;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/zr_sync_fifo.sv
// Single-clock FIFO with occupancy output; head entry is visible on dout while non-empty.
module zr_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/zr_uart_tx.sv
// UART transmitter: byte FIFO feeding a start/data/stop serialiser with per-frame latched format.
module zr_uart_tx
    import zr_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ctrl_en,
    input  logic [DIV_WIDTH-1:0]          ctrl_baud_clks,
    input  logic [3:0]                    ctrl_bits,
    input  logic [1:0]                    ctrl_stops,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    uart_state_t          state;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] period;
    logic [DIV_WIDTH-1:0] new_period;
    logic [7:0]           shift;
    logic [2:0]           bit_idx;
    logic [2:0]           bits_m1;
    logic                 stop_idx;
    logic                 stops_m1;
    logic [7:0]           fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 last_stop;
    logic                 start_frame;

    zr_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_valid),
        .din   (wr_data),
        .pop   (start_frame),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wr_ready    = !fifo_full;
    assign new_period  = (ctrl_baud_clks == '0) ? ONE : ctrl_baud_clks;
    assign bit_end     = (cnt == '0);
    assign last_stop   = (state == ST_STOP) && bit_end && (stop_idx == stops_m1);
    // A new frame starts from IDLE or straight out of the final stop bit, so frames abut.
    assign start_frame = ctrl_en && !fifo_empty && ((state == ST_IDLE) || last_stop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
            cnt      <= '0;
            period   <= '0;
            shift    <= '0;
            bit_idx  <= '0;
            bits_m1  <= '0;
            stop_idx <= 1'b0;
            stops_m1 <= 1'b0;
        end else if (start_frame) begin
            state    <= ST_START;
            txd      <= 1'b0;
            busy     <= 1'b1;
            shift    <= fifo_dout;
            period   <= new_period;
            cnt      <= new_period - ONE;
            bits_m1  <= clamp_bits_m1(ctrl_bits);
            stops_m1 <= clamp_stops_m1(ctrl_stops);
        end else if (state != ST_IDLE) begin
            if (!bit_end) begin
                cnt <= cnt - ONE;
            end else begin
                cnt <= period - ONE;
                case (state)
                    ST_START: begin
                        state   <= ST_DATA;
                        txd     <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= '0;
                    end
                    ST_DATA: begin
                        if (bit_idx == bits_m1) begin
                            state    <= ST_STOP;
                            txd      <= 1'b1;
                            stop_idx <= 1'b0;
                        end else begin
                            txd     <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    ST_STOP: begin
                        if (stop_idx == stops_m1) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            txd   <= 1'b1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zr_uart_tx.sv
// Self-checking bench for zr_uart_tx: table vectors, hand-written corner sequences, random frames.
module tb_zr_uart_tx;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned DIV_WIDTH  = 16;

    logic        clk;
    logic        rst_n;
    logic        ctrl_en;
    logic [15:0] ctrl_baud_clks;
    logic [3:0]  ctrl_bits;
    logic [1:0]  ctrl_stops;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        txd;
    logic        busy;
    logic [2:0]  fifo_level;

    int n_assert = 0;
    int n_fail   = 0;

    zr_uart_tx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_WIDTH  (DIV_WIDTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctrl_en        (ctrl_en),
        .ctrl_baud_clks (ctrl_baud_clks),
        .ctrl_bits      (ctrl_bits),
        .ctrl_stops     (ctrl_stops),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .txd            (txd),
        .busy           (busy),
        .fifo_level     (fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef bit bitq_t[$];

    typedef struct {
        logic [7:0] data;
        int         baud;
        int         bits;
        int         stops;
        int         exp_cycles;
        logic [7:0] exp_rx;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame format rules in plain arithmetic.
    function automatic int eff_per(int baud);
        return (baud < 1) ? 1 : baud;
    endfunction
    function automatic int eff_bits(int bits);
        return (bits < 5) ? 5 : ((bits > 8) ? 8 : bits);
    endfunction
    function automatic int eff_stops(int stops);
        return (stops < 1) ? 1 : ((stops > 2) ? 2 : stops);
    endfunction

    function automatic bitq_t build_wave(logic [7:0] d, int baud, int bits, int stops);
        bitq_t sym;
        bitq_t q;
        sym.push_back(1'b0);
        for (int j = 0; j < eff_bits(bits); j++) sym.push_back(d[j]);
        for (int j = 0; j < eff_stops(stops); j++) sym.push_back(1'b1);
        foreach (sym[k])
            for (int r = 0; r < eff_per(baud); r++) q.push_back(sym[k]);
        return q;
    endfunction

    // Starts on the negedge of the frame's first cycle, returns on the negedge just after it.
    task automatic expect_frame(input logic [7:0] d, input int baud, input int bits,
                                input int stops, input int exp_cycles,
                                input logic [7:0] exp_rx, input string name);
        bitq_t q;
        bitq_t smp;
        int bad = 0;
        int first_bad = -1;
        int busy_hi = 0;
        int per;
        int nb;
        int ns;
        logic [7:0] rx;
        logic rx_err;
        q = build_wave(d, baud, bits, stops);
        for (int i = 0; i < q.size(); i++) begin
            smp.push_back(txd);
            if (txd !== q[i]) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
            if (busy === 1'b1) busy_hi++;
            @(negedge clk);
        end
        per = eff_per(baud);
        nb  = eff_bits(bits);
        ns  = eff_stops(stops);
        rx = '0;
        rx_err = (smp[per / 2] != 1'b0);
        for (int j = 0; j < nb; j++) rx[j] = smp[(1 + j) * per + per / 2];
        for (int j = 0; j < ns; j++)
            if (smp[(1 + nb + j) * per + per / 2] != 1'b1) rx_err = 1'b1;
        if (bad != 0) $display("  %s first wave deviation at cycle %0d", name, first_bad);
        check({name, " wave deviations"}, bad, 0);
        check({name, " model length"}, q.size(), exp_cycles);
        check({name, " busy cycles"}, busy_hi, exp_cycles);
        check({name, " rx_data"}, rx, exp_rx);
        check({name, " rx_err"}, rx_err, 0);
    endtask

    // Called on a negedge; returns on the negedge following the accepting edge.
    task automatic write_byte(input logic [7:0] b);
        int guard = 0;
        wr_valid = 1'b1;
        wr_data  = b;
        while (!wr_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) check("write handshake timeout", 1, 0);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic set_cfg(input int baud, input int bits, input int stops);
        ctrl_baud_clks = 16'(baud);
        ctrl_bits      = 4'(bits);
        ctrl_stops     = 2'(stops);
    endtask

    vec_t vecs[7];

    initial begin
        logic [7:0] bq[$];
        int bad;
        int baud;
        int bits;
        int stops;
        int n;

        vecs[0] = '{8'h55, 2, 8,  1, 20, 8'h55};
        vecs[1] = '{8'hFF, 3, 7,  2, 30, 8'h7F};
        vecs[2] = '{8'hA3, 0, 8,  1, 10, 8'hA3};
        vecs[3] = '{8'h3C, 1, 3,  0,  7, 8'h1C};
        vecs[4] = '{8'h96, 2, 15, 3, 22, 8'h96};
        vecs[5] = '{8'h0F, 4, 5,  2, 32, 8'h0F};
        vecs[6] = '{8'h80, 1, 6,  1,  8, 8'h00};

        rst_n = 1'b0;
        ctrl_en = 1'b1;
        set_cfg(2, 8, 1);
        wr_valid = 1'b0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        check("reset txd", txd, 1);
        check("reset busy", busy, 0);
        check("reset fifo_level", fifo_level, 0);
        check("reset wr_ready", wr_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: single frames, idle before and after.
        foreach (vecs[i]) begin
            set_cfg(vecs[i].baud, vecs[i].bits, vecs[i].stops);
            write_byte(vecs[i].data);
            check($sformatf("vec%0d idle before start", i), txd, 1);
            @(negedge clk);
            expect_frame(vecs[i].data, vecs[i].baud, vecs[i].bits, vecs[i].stops,
                         vecs[i].exp_cycles, vecs[i].exp_rx, $sformatf("vec%0d", i));
            check($sformatf("vec%0d txd after", i), txd, 1);
            check($sformatf("vec%0d busy after", i), busy, 0);
        end

        // Full FIFO back-pressure, dropped write, then five contiguous frames.
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};
        ctrl_en = 1'b0;
        set_cfg(2, 8, 1);
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1;
            wr_data  = bq[k];
            @(negedge clk);
        end
        check("full fifo_level", fifo_level, 4);
        check("full wr_ready", wr_ready, 0);
        wr_data = 8'hEE;
        @(negedge clk);
        check("write while full ignored", fifo_level, 4);
        wr_data = bq[4];
        check("wr_ready low before pop", wr_ready, 0);
        ctrl_en = 1'b1;
        @(negedge clk);
        check("wr_ready after first pop", wr_ready, 1);
        check("level after first pop", fifo_level, 3);
        fork
            begin
                @(negedge clk);
                wr_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 5; k++)
                    expect_frame(bq[k], 2, 8, 1, 20, bq[k], $sformatf("burst%0d", k));
            end
        join
        check("burst busy after", busy, 0);
        check("burst level after", fifo_level, 0);

        // Baud change mid-frame only affects the following frame.
        ctrl_en = 1'b0;
        write_byte(8'h12);
        write_byte(8'h34);
        ctrl_en = 1'b1;
        @(negedge clk);
        fork
            begin
                expect_frame(8'h12, 2, 8, 1, 20, 8'h12, "baud2 frame");
                expect_frame(8'h34, 4, 8, 1, 40, 8'h34, "baud4 frame");
            end
            begin
                repeat (5) @(negedge clk);
                ctrl_baud_clks = 16'd4;
            end
        join
        check("baud change busy after", busy, 0);

        // Hold with ctrl_en low, release, then reset in the middle of DATA.
        set_cfg(2, 8, 1);
        ctrl_en = 1'b0;
        write_byte(8'hA5);
        write_byte(8'h5C);
        write_byte(8'hC3);
        bad = 0;
        repeat (6) begin
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("disabled txd idle cycles bad", bad, 0);
        check("disabled fifo_level", fifo_level, 3);
        ctrl_en = 1'b1;
        @(negedge clk);
        check("enable start bit", txd, 0);
        check("enable busy", busy, 1);
        check("enable fifo_level", fifo_level, 2);
        repeat (4) @(negedge clk);
        check("A5 data bit1", txd, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort txd", txd, 1);
        check("abort busy", busy, 0);
        check("abort fifo_level", fifo_level, 0);
        check("abort wr_ready", wr_ready, 1);
        rst_n = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("no frames after reset", bad, 0);

        // Random single frames against the reference model.
        for (int r = 0; r < 12; r++) begin
            logic [7:0] d;
            d = 8'($urandom);
            baud = int'($urandom_range(0, 4));
            bits = int'($urandom_range(0, 15));
            stops = int'($urandom_range(0, 3));
            set_cfg(baud, bits, stops);
            write_byte(d);
            @(negedge clk);
            expect_frame(d, baud, bits, stops,
                         (1 + eff_bits(bits) + eff_stops(stops)) * eff_per(baud),
                         d & 8'((1 << eff_bits(bits)) - 1), $sformatf("rand%0d", r));
            check($sformatf("rand%0d idle after", r), txd, 1);
        end

        // Random bursts: streamed writes must produce back-to-back frames.
        for (int r = 0; r < 3; r++) begin
            baud = int'($urandom_range(1, 3));
            bits = int'($urandom_range(5, 8));
            stops = int'($urandom_range(1, 2));
            n = int'($urandom_range(2, 6));
            set_cfg(baud, bits, stops);
            bq.delete();
            for (int k = 0; k < n; k++) bq.push_back(8'($urandom));
            write_byte(bq[0]);
            @(negedge clk);
            fork
                begin
                    for (int k = 1; k < n; k++) write_byte(bq[k]);
                end
                begin
                    for (int k = 0; k < n; k++)
                        expect_frame(bq[k], baud, bits, stops,
                                     (1 + bits + stops) * baud,
                                     bq[k] & 8'((1 << bits) - 1),
                                     $sformatf("rburst%0d.%0d", r, k));
                end
            join
            check($sformatf("rburst%0d idle after", r), busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/zr_uart_tx.md
ZR_UART_TX -- requirements
Module: zr_uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter DIV_WIDTH, default 16, width of the baud divider.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port ctrl_en  in  1  transmit enable; gates the start of new frames.
REQ-006 SHALL have port ctrl_baud_clks  in  DIV_WIDTH  clk cycles per bit period.
REQ-007 SHALL have port ctrl_bits  in  4  data bits per frame, legal 5..8.
REQ-008 SHALL have port ctrl_stops  in  2  stop bits per frame, legal 1..2.
REQ-009 SHALL have port wr_valid  in  1  write request.
REQ-010 SHALL have port wr_data  in  8  byte to transmit.
REQ-011 SHALL have port wr_ready  out  1  FIFO can accept a byte.
REQ-012 SHALL have port txd  out  1  serial output, registered, idle high.
REQ-013 SHALL have port busy  out  1  frame in progress.
REQ-014 SHALL have port fifo_level  out  $clog2(FIFO_DEPTH)+1  stored byte count.

Function
REQ-015 SHALL accept a byte on each edge where wr_valid and wr_ready are both high; wr_ready = (fifo_level != FIFO_DEPTH), no full-FIFO bypass.
REQ-016 SHALL drop nothing: wr_valid while full is not accepted and wr_data is ignored.
REQ-017 SHALL implement FSM IDLE -> START -> DATA -> STOP -> (START or IDLE).
REQ-018 SHALL leave IDLE, popping one byte, on the edge where ctrl_en is high and FIFO is non-empty; txd goes low from that edge (one cycle after the acceptance edge into an empty FIFO).
REQ-019 SHALL latch ctrl_baud_clks, ctrl_bits, ctrl_stops at frame start; changes mid-frame affect the next frame only.
REQ-020 SHALL hold each bit for max(ctrl_baud_clks,1) cycles; value 0 treated as 1.
REQ-021 SHALL send start bit 0, then ctrl_bits data bits LSB first, then ctrl_stops stop bits of 1; unsent upper bits ignored.
REQ-022 SHALL clamp ctrl_bits <5 to 5 and >8 to 8; ctrl_stops 0 treated as 1, 3 as 2.
REQ-023 SHALL, at end of last stop bit, go directly to START with the next byte if ctrl_en and FIFO non-empty (no idle gap), else IDLE.
REQ-024 SHALL complete the current frame when ctrl_en drops mid-frame, then stay IDLE.
REQ-025 SHALL assert busy in START, DATA, STOP; low in IDLE.
REQ-026 SHALL update fifo_level by +1, -1 or 0 for simultaneous push and pop.

Reset
REQ-027 SHALL, while rst_n low at an edge: txd=1, busy=0, FSM=IDLE, FIFO empty (fifo_level=0, wr_ready=1), counters zero.
REQ-028 SHALL abort any frame in progress on reset; txd high from the reset edge, FIFO contents discarded.

Structure
REQ-029 SHALL take FSM state enum and ctrl_bits/ctrl_stops clamp limits from shared package zr_uart_pkg.
REQ-030 SHALL implement the FIFO as sub-module zr_sync_fifo (parameterised width/depth, level output).
REQ-031 SHALL be synthesisable; no delays, no initial blocks.

Verification
REQ-032 SHALL check: baud=2, bits=8, stops=1, write 0x55 -> txd 0,1,0,1,0,1,0,1,0,1 each 2 cycles, busy high exactly 20 cycles, matched by uart_model rx_data=0x55, rx_err=0.
REQ-033 SHALL check: write 5 bytes back-to-back, depth 4 -> wr_ready low on 5th until first pop; 5 frames contiguous, no idle cycle between stop and start.
REQ-034 SHALL check: bits=7, stops=2, baud=3, write 0xFF -> 10 bit periods (30 cycles), bit 7 never driven.
REQ-035 SHALL check: baud changed 2->4 mid-frame -> current frame stays 2 cycles/bit, next frame 4.
REQ-036 SHALL check: rst_n low during DATA of 0xA5 with 2 bytes queued -> txd=1, busy=0, fifo_level=0 next cycle; no further frames.
REQ-037 SHALL check: ctrl_en=0 with 3 bytes queued -> txd stays 1, fifo_level=3; ctrl_en=1 -> txd low after one edge.
